multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control FSM for the multi-cycle RV32I core. It sequences the load enables of the datapath's n-bit registers (PC, IR/old-PC, A/B operand, ALU-out, MDR) and the register-file write. It also runs the req/ready handshake to the shared instruction/data memory. It sits between the IR opcode field and the datapath register bank, one instruction at a time.

Parameters:
TIMEOUT, 15, max cycles mem_req may wait for mem_ready (used only with MCC_MEM_TIMEOUT_EN)
TW, 4, width of the timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
run  in  1  level; leave IDLE and start fetching while high
opcode  in  7  IR[6:0] (IR register output)
funct3_is_store  in  1  unused-safe hint; ignored (tie 0)
branch_taken  in  1  datapath comparator result, valid in BRANCH
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req (STORE only)
pc_load  out  1  PC register load enable
pc_src  out  2  0=PC+4, 1=old_pc+imm, 2=ALU result (JALR)
ir_load  out  1  IR and old-PC register load enable
ab_load  out  1  A/B operand register load enable
alu_out_load  out  1  ALU-out register load enable
mdr_load  out  1  MDR load enable
rf_we  out  1  register-file write enable
wb_sel  out  2  0=ALU-out, 1=MDR, 2=PC (link), 3=imm (LUI)
alu_src_a  out  1  0=A, 1=old_pc (AUIPC)
alu_src_b  out  1  0=B, 1=imm
retire  out  1  one-cycle pulse at last cycle of each instruction
err  out  1  sticky; illegal opcode (or timeout)
state_o  out  4  current state encoding, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, JUMP=7, ERROR=8.
- rst asserted: state=IDLE immediately; err=0; timeout counter=0. All outputs are 0 while in IDLE.
- Outputs are decoded combinationally from the state plus the handshake inputs. The state is the only register, apart from err and the counter.
- IDLE: go to FETCH when run=1.
- FETCH: mem_req=1, mem_we=0. Stay while mem_ready=0.
  - On mem_ready=1, in the same cycle: ir_load=1, pc_load=1, pc_src=0. Next state is DECODE.
- DECODE: ab_load=1. Next state by opcode:
  - 0110011, 0010011, 0000011, 0100011, 0010111 -> EXEC
  - 0110111 -> WB
  - 1100011 -> BRANCH
  - 1101111, 1100111 -> JUMP
  - any other opcode -> ERROR
- EXEC: alu_out_load=1.
  - alu_src_b=1 for all except R-type (0110011). alu_src_a=1 only for AUIPC.
  - Next state: LOAD/STORE -> MEM, else -> WB.
- MEM: mem_req=1, mem_we=1 for STORE. Stay while mem_ready=0.
  - On mem_ready with LOAD: mdr_load=1, next WB.
  - On mem_ready with STORE: retire=1, next FETCH (IDLE if run=0).
- WB: rf_we=1, retire=1. wb_sel=1 for LOAD, 3 for LUI, else 0. Next FETCH (IDLE if run=0).
- BRANCH: pc_load=branch_taken, pc_src=1, retire=1. Next FETCH/IDLE.
- JUMP: rf_we=1, wb_sel=2, pc_load=1, pc_src=1 (JAL) or 2 (JALR), retire=1. Next FETCH/IDLE.
- ERROR: err=1 (sticky), no enables asserted. Held until rst.
- Cycle counts with 1-cycle memory: R/I/AUIPC 4, LOAD 5, STORE 4, LUI 3, BRANCH 3, JAL/JALR 3.
- opcode is sampled only in states DECODE..JUMP; the IR is stable there because ir_load is only asserted in FETCH.
- run dropping mid-instruction: the instruction completes; the FSM returns to IDLE instead of FETCH.
- mem_req is never deasserted before mem_ready; exactly one completion per request.

Optional Feature:
MCC_MEM_TIMEOUT_EN:
- Defined:
  - The counter increments each cycle in FETCH/MEM while mem_ready=0, and clears on mem_ready or on state exit.
  - When the counter reaches TIMEOUT with mem_ready still 0: go to ERROR, err=1, mem_req drops.
- Undefined: no counter logic; waits indefinitely.

Decomposition:
- Package mcc_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - pc_src and wb_sel encodings
- The FSM is a single module.
- One natural sub-module: mcc_timeout_cnt (TW-bit counter with clear/inc/hit), instantiated only under the macro.

Test Plan:
- rst=1 mid-MEM with mem_req=1 -> same cycle: state_o=0, mem_req=0, err=0; after release with run=0, stays IDLE.
- run=1, opcode=0110011, mem_ready=1 always -> states 1,2,3,5. ir_load/pc_load in cycle 1; rf_we=1, wb_sel=0, retire=1 in cycle 4.
- LOAD (0000011) with mem_ready low for 3 cycles in MEM -> mem_req held 4 cycles, mdr_load=1 only on the ready cycle, WB with wb_sel=1; total 8 cycles.
- BRANCH with branch_taken=1 then 0 -> pc_load=1/pc_src=1 in the first, pc_load=0 in the second; 3 cycles each, one retire pulse each.
- opcode=0000000 at DECODE -> ERROR, err=1 sticky; no enables asserted thereafter; cleared only by rst.
- With MCC_MEM_TIMEOUT_EN, TIMEOUT=15, mem_ready stuck 0 in FETCH -> err=1 after 15 wait cycles, state_o=8. Without the macro -> still FETCH after 100 cycles.

Source files
------------

// File: rtl/mcc_pkg.sv
// rtl/mcc_pkg.sv - state, opcode and mux-select constants for the multi-cycle control FSM
package mcc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_EXEC   = 4'd3;
  localparam state_t S_MEM    = 4'd4;
  localparam state_t S_WB     = 4'd5;
  localparam state_t S_BRANCH = 4'd6;
  localparam state_t S_JUMP   = 4'd7;
  localparam state_t S_ERROR  = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_AUIPC: decode_next = S_EXEC;
      OP_LUI:                                  decode_next = S_WB;
      OP_BRANCH:                               decode_next = S_BRANCH;
      OP_JAL, OP_JALR:                         decode_next = S_JUMP;
      default:                                 decode_next = S_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/mcc_timeout_cnt.sv
// rtl/mcc_timeout_cnt.sv - saturating wait counter flagging a stalled memory request
module mcc_timeout_cnt #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [TW-1:0] cnt;

  assign hit = (cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !hit)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM; MCC_MEM_TIMEOUT_EN adds a memory wait timeout
module multicycle_ctrl
  import mcc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       funct3_is_store,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       ir_load,
  output logic       ab_load,
  output logic       alu_out_load,
  output logic       mdr_load,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       retire,
  output logic       err,
  output logic [3:0] state_o
);

  state_t state, state_n;
  logic   tmo_hit;
  logic   unused_hint;

  assign unused_hint = funct3_is_store;

`ifdef MCC_MEM_TIMEOUT_EN
  logic waiting;

  // Any cycle not spent stalled on memory (ready, or another state) resets the count.
  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

  mcc_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (!waiting),
    .inc (waiting),
    .hit (tmo_hit)
  );
`else
  logic [TW-1:0] unused_cfg;

  assign unused_cfg = TW'(TIMEOUT);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    pc_load      = 1'b0;
    pc_src       = PC_PLUS4;
    ir_load      = 1'b0;
    ab_load      = 1'b0;
    alu_out_load = 1'b0;
    mdr_load     = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    retire       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run)
          state_n = S_FETCH;
      end
      S_FETCH: begin
        mem_req = !tmo_hit;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          pc_src  = PC_PLUS4;
          state_n = S_DECODE;
        end else if (tmo_hit) begin
          state_n = S_ERROR;
        end
      end
      S_DECODE: begin
        ab_load = 1'b1;
        state_n = decode_next(opcode);
      end
      S_EXEC: begin
        alu_out_load = 1'b1;
        alu_src_b    = (opcode != OP_R);
        alu_src_a    = (opcode == OP_AUIPC);
        state_n      = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = !tmo_hit;
        mem_we  = (opcode == OP_STORE) && !tmo_hit;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            retire  = 1'b1;
            state_n = run ? S_FETCH : S_IDLE;
          end else begin
            mdr_load = 1'b1;
            state_n  = S_WB;
          end
        end else if (tmo_hit) begin
          state_n = S_ERROR;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        wb_sel  = (opcode == OP_LOAD) ? WB_MDR : (opcode == OP_LUI) ? WB_IMM : WB_ALU;
        state_n = run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        pc_load = branch_taken;
        pc_src  = PC_REL;
        retire  = 1'b1;
        state_n = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        rf_we   = 1'b1;
        wb_sel  = WB_PC;
        pc_load = 1'b1;
        pc_src  = (opcode == OP_JALR) ? PC_ALU : PC_REL;
        retire  = 1'b1;
        state_n = run ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        state_n = S_ERROR;
      end
      default: begin
        state_n = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == S_ERROR)
        err <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] AU_OP  = 7'b0010111;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic       pcl;
    logic [1:0] pcs;
    logic       irl;
    logic       abl;
    logic       alul;
    logic       mdrl;
    logic       rfwe;
    logic [1:0] wbs;
    logic       asa;
    logic       asb;
    logic       ret;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, pc_load, ir_load, ab_load, alu_out_load, mdr_load;
  logic       rf_we, alu_src_a, alu_src_b, retire, err;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] state_o;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t exp_q[$];
  string tag_q[$];
  vec_t v_idle, v_fetch, v_fwait, v_dec, v_err;

  multicycle_ctrl #(.TIMEOUT(15), .TW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .opcode          (opcode),
    .funct3_is_store (1'b0),
    .branch_taken    (branch_taken),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .pc_load         (pc_load),
    .pc_src          (pc_src),
    .ir_load         (ir_load),
    .ab_load         (ab_load),
    .alu_out_load    (alu_out_load),
    .mdr_load        (mdr_load),
    .rf_we           (rf_we),
    .wb_sel          (wb_sel),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .retire          (retire),
    .err             (err),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] st, input logic req, input logic we,
                              input logic pcl, input logic [1:0] pcs, input logic irl,
                              input logic abl, input logic alul, input logic mdrl,
                              input logic rfwe, input logic [1:0] wbs, input logic asa,
                              input logic asb, input logic ret, input logic er);
    vec_t v;
    v = '{st: st, req: req, we: we, pcl: pcl, pcs: pcs, irl: irl, abl: abl, alul: alul,
          mdrl: mdrl, rfwe: rfwe, wbs: wbs, asa: asa, asb: asb, ret: ret, err: er};
    return v;
  endfunction

  task automatic check();
    vec_t  e, obs;
    string t;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = '{st: state_o, req: mem_req, we: mem_we, pcl: pc_load, pcs: pc_src, irl: ir_load,
            abl: ab_load, alul: alu_out_load, mdrl: mdr_load, rfwe: rf_we, wbs: wb_sel,
            asa: alu_src_a, asb: alu_src_b, ret: retire, err: err};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be, compare mid-cycle.
  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic rd, input logic bt, input vec_t e);
    run = r; opcode = op; mem_ready = rd; branch_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic prelude(input string tag, input logic [6:0] op);
    step({tag, "_fetch"}, 1, op, 1, 0, v_fetch);
    step({tag, "_dec"},   1, op, 1, 0, v_dec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v_idle  = mk(0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    v_fetch = mk(1, 1,0,1,0,1,0,0,0,0,0,0,0,0,0);
    v_fwait = mk(1, 1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    v_dec   = mk(2, 0,0,0,0,0,1,0,0,0,0,0,0,0,0);
    v_err   = mk(8, 0,0,0,0,0,0,0,0,0,0,0,0,0,1);

    rst = 1'b1; run = 1'b0; opcode = '0; mem_ready = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 1, R_OP, 1, 0, v_idle);
    rst = 1'b0;
    step("idle_hold", 0, R_OP, 1, 0, v_idle);
    step("idle_go",   1, R_OP, 1, 0, v_idle);

    prelude("r", R_OP);
    step("r_exec", 1, R_OP, 1, 0, mk(3, 0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    step("r_wb",   1, R_OP, 1, 0, mk(5, 0,0,0,0,0,0,0,0,1,0,0,0,1,0));

    prelude("ld", LD_OP);
    step("ld_exec", 1, LD_OP, 1, 0, mk(3, 0,0,0,0,0,0,1,0,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++)
      step("ld_mem_wait", 1, LD_OP, 0, 0, mk(4, 1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("ld_mem_rdy", 1, LD_OP, 1, 0, mk(4, 1,0,0,0,0,0,0,1,0,0,0,0,0,0));
    step("ld_wb",      1, LD_OP, 1, 0, mk(5, 0,0,0,0,0,0,0,0,1,1,0,0,1,0));

    prelude("st", ST_OP);
    step("st_exec", 1, ST_OP, 1, 0, mk(3, 0,0,0,0,0,0,1,0,0,0,0,1,0,0));
    step("st_mem",  1, ST_OP, 1, 0, mk(4, 1,1,0,0,0,0,0,0,0,0,0,0,1,0));

    prelude("au", AU_OP);
    step("au_exec", 1, AU_OP, 1, 0, mk(3, 0,0,0,0,0,0,1,0,0,0,1,1,0,0));
    step("au_wb",   1, AU_OP, 1, 0, mk(5, 0,0,0,0,0,0,0,0,1,0,0,0,1,0));

    prelude("lui", LUI_OP);
    step("lui_wb", 1, LUI_OP, 1, 0, mk(5, 0,0,0,0,0,0,0,0,1,3,0,0,1,0));

    prelude("bt", BR_OP);
    step("br_taken", 1, BR_OP, 1, 1, mk(6, 0,0,1,1,0,0,0,0,0,0,0,0,1,0));
    prelude("bn", BR_OP);
    step("br_not",   1, BR_OP, 1, 0, mk(6, 0,0,0,1,0,0,0,0,0,0,0,0,1,0));

    prelude("jal", JAL_OP);
    step("jal_jump", 1, JAL_OP, 1, 0, mk(7, 0,0,1,1,0,0,0,0,1,2,0,0,1,0));
    prelude("jalr", JR_OP);
    step("jalr_jump", 0, JR_OP, 1, 0, mk(7, 0,0,1,2,0,0,0,0,1,2,0,0,1,0));
    step("jalr_idle", 0, JR_OP, 1, 0, v_idle);

    step("rm_go", 1, LD_OP, 1, 0, v_idle);
    prelude("rm", LD_OP);
    step("rm_exec", 1, LD_OP, 1, 0, mk(3, 0,0,0,0,0,0,1,0,0,0,0,1,0,0));
    step("rm_mem",  1, LD_OP, 0, 0, mk(4, 1,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    #1;
    step("rm_rst", 0, LD_OP, 0, 0, v_idle);
    rst = 1'b0;
    step("rm_hold0", 0, LD_OP, 1, 0, v_idle);
    step("rm_hold1", 0, LD_OP, 1, 0, v_idle);

    step("er_go", 1, 7'h00, 1, 0, v_idle);
    prelude("er", 7'h00);
    for (int i = 0; i < 4; i++)
      step("er_sticky", i[0], R_OP, 1, 1, v_err);
    rst = 1'b1;
    #1;
    step("er_rst", 0, R_OP, 1, 0, v_idle);
    rst = 1'b0;
    step("er_clear", 0, R_OP, 1, 0, v_idle);

    step("to_go", 1, R_OP, 0, 0, v_idle);
`ifdef MCC_MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++)
      step("to_wait", 1, R_OP, 0, 0, v_fwait);
    step("to_hit", 1, R_OP, 0, 0, mk(1, 0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("to_err", 1, R_OP, 0, 0, v_err);
`else
    for (int i = 0; i < 100; i++)
      step("to_wait", 1, R_OP, 0, 0, v_fwait);
    step("to_still", 1, R_OP, 0, 0, v_fwait);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
